// File: rtl/flash_stream_unpack_if.sv
// -----------------------------------------------------------------------------
// flash_stream_unpack_if
//   Groups the two streaming sides of flash_stream_unpack:
//     - spi_fifo read port (fill request, empty/low status, pop, head word)
//     - payload byte stream (byte, valid, ready)
//   modport master : the unpacker (drives fill, pop and the byte stream)
//   modport slave  : the environment (FIFO plus downstream byte consumer)
// -----------------------------------------------------------------------------
interface flash_stream_unpack_if;
  logic        fill;        // session active, to spi_fifo i_fill
  logic        fifo_empty;  // FIFO has no word at its head
  logic        fifo_low;    // FIFO nearly empty (status only)
  logic        fifo_rd;     // pop head word this cycle
  logic [31:0] fifo_dout;   // head word, first-word-fall-through
  logic [7:0]  byte_data;   // payload byte
  logic        byte_vld;    // byte_data valid
  logic        byte_rdy;    // consumer ready

  modport master (
    output fill, fifo_rd, byte_data, byte_vld,
    input  fifo_empty, fifo_low, fifo_dout, byte_rdy
  );

  modport slave (
    input  fill, fifo_rd, byte_data, byte_vld,
    output fifo_empty, fifo_low, fifo_dout, byte_rdy
  );
endinterface

// File: rtl/flash_stream_unpack.sv
// -----------------------------------------------------------------------------
// flash_stream_unpack
//   Reads a flash session out of spi_fifo: raises fill, parses one header word
//   (magic in [31:24], payload byte length in [23:0]), unpacks the payload
//   words into a byte stream (byte 0 = bits [7:0]) and ends the session by
//   dropping fill for at least one cycle.
//
//   Optional feature macro: CHECKSUM_EN
//     defined   : a 16-bit sum of accepted payload bytes is compared with the
//                 low half of the trailer word that follows the payload.
//     undefined : no trailer is read; errors come from header checks only.
//
// Ports
//   clk2x      clock (SPI I/O domain)          resetn   async active-low reset
//   i_start    session start pulse (IDLE only)  i_abort  level, abort session
//   io_strm    FIFO read side + byte stream (flash_stream_unpack_if.master)
//   o_len      payload length from the header   o_busy   not IDLE
//   o_done     normal completion pulse          o_err    sticky, cleared by start
//   o_starved  DATA, no byte held, FIFO low
// -----------------------------------------------------------------------------
module flash_stream_unpack #(
  parameter logic [7:0]  C_MAGIC   = 8'hA5,
  parameter logic [23:0] C_MAX_LEN = 24'h0FFFFF
) (
  input  logic                         clk2x,
  input  logic                         resetn,
  input  logic                         i_start,
  input  logic                         i_abort,
  flash_stream_unpack_if.master        io_strm,
  output logic [23:0]                  o_len,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic                         o_starved
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_END  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t C_AFTER_PAYLOAD = S_CHK;

  function automatic logic [15:0] f_sum_add(input logic [15:0] sum, input logic [7:0] b);
    f_sum_add = sum + {8'h00, b};
  endfunction
`else
  localparam state_t C_AFTER_PAYLOAD = S_END;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_word;      // current payload word, shifted right as bytes leave
  logic        r_vld;       // r_word holds at least one unsent byte
  logic [1:0]  r_idx;       // bytes of r_word already accepted
  logic [23:0] r_cnt;       // payload bytes still to be accepted
  logic [23:0] r_len;
  logic        r_fill;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_starved;
`ifdef CHECKSUM_EN
  logic [15:0] r_sum;
`endif

  logic        w_pop;
  logic        w_accept;
  logic        w_last_byte;
  logic        w_word_done;
  logic        w_need_word;
  logic        w_hdr_bad;
  logic [23:0] w_hdr_len;

  assign w_hdr_len   = io_strm.fifo_dout[23:0];
  assign w_hdr_bad   = (io_strm.fifo_dout[31:24] != C_MAGIC) || (w_hdr_len > C_MAX_LEN);
  assign w_accept    = r_vld & io_strm.byte_rdy;
  assign w_last_byte = w_accept & (r_cnt == 24'd1);
  assign w_word_done = w_accept & (r_idx == 2'd3);
  // A new word is wanted when nothing is held, or the held word is finishing
  // this cycle and more payload remains; this keeps one byte per cycle.
  assign w_need_word = ~r_vld | (w_word_done & ~w_last_byte);

  assign io_strm.fill      = r_fill;
  assign io_strm.fifo_rd   = w_pop;
  assign io_strm.byte_data = r_word[7:0];
  assign io_strm.byte_vld  = r_vld;
  assign o_len             = r_len;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_err             = r_err;
  assign o_starved         = r_starved;

  // Next-state decode and FIFO pop request
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (i_start && !i_abort) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (!io_strm.fifo_empty) begin
          w_pop = 1'b1;
          if (w_hdr_bad) begin
            w_state_nxt = S_ERR;
          end else if (w_hdr_len == 24'd0) begin
            w_state_nxt = C_AFTER_PAYLOAD;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_DATA: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (w_need_word && !io_strm.fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_pop = 1'b0;
          end
          if (w_last_byte) begin
            w_state_nxt = C_AFTER_PAYLOAD;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_CHK: begin
`ifdef CHECKSUM_EN
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (!io_strm.fifo_empty) begin
          w_pop = 1'b1;
          if (io_strm.fifo_dout[15:0] != r_sum) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_END;
          end
        end else begin
          w_state_nxt = S_CHK;
        end
`else
        w_state_nxt = S_END;
`endif
      end
      S_ERR: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk2x or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered session status outputs, decoded from the next state
  always_ff @(posedge clk2x or negedge resetn) begin
    if (!resetn) begin
      r_fill    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_starved <= 1'b0;
    end else begin
      // fill drops in END so spi_fifo sees a low cycle between sessions
      r_fill    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_END);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_END) && (r_state != S_ERR);
      r_starved <= (r_state == S_DATA) && !r_vld && io_strm.fifo_low;
      if ((r_state == S_IDLE) && (w_state_nxt == S_FILL)) begin
        r_err <= 1'b0;
      end else if (w_state_nxt == S_ERR) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Payload word register: load on pop, shift out one byte per handshake
  always_ff @(posedge clk2x or negedge resetn) begin
    if (!resetn) begin
      r_word <= 32'h0000_0000;
      r_vld  <= 1'b0;
      r_idx  <= 2'd0;
    end else if ((r_state != S_DATA) || (w_state_nxt == S_IDLE)) begin
      r_vld  <= 1'b0;
      r_idx  <= 2'd0;
    end else if (w_pop) begin
      r_word <= io_strm.fifo_dout;
      r_vld  <= 1'b1;
      r_idx  <= 2'd0;
    end else if (w_accept) begin
      r_word <= {8'h00, r_word[31:8]};
      r_idx  <= r_idx + 2'd1;
      // leftover bytes of a partial last word are simply dropped
      if ((r_idx == 2'd3) || (r_cnt == 24'd1)) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= 1'b1;
      end
    end else begin
      r_vld  <= r_vld;
    end
  end

  // Header length capture and remaining-byte counter
  always_ff @(posedge clk2x or negedge resetn) begin
    if (!resetn) begin
      r_len <= 24'd0;
      r_cnt <= 24'd0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_FILL)) begin
      r_len <= 24'd0;
      r_cnt <= 24'd0;
    end else if ((r_state == S_HDR) && w_pop && !w_hdr_bad) begin
      r_len <= w_hdr_len;
      r_cnt <= w_hdr_len;
    end else if (w_accept) begin
      r_cnt <= r_cnt - 24'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

`ifdef CHECKSUM_EN
  // Running 16-bit sum of accepted payload bytes
  always_ff @(posedge clk2x or negedge resetn) begin
    if (!resetn) begin
      r_sum <= 16'h0000;
    end else if (r_state == S_HDR) begin
      r_sum <= 16'h0000;
    end else if (w_accept) begin
      r_sum <= f_sum_add(r_sum, r_word[7:0]);
    end else begin
      r_sum <= r_sum;
    end
  end
`endif

endmodule

// File: tb/tb_flash_stream_unpack.sv
// -----------------------------------------------------------------------------
// tb_flash_stream_unpack
//   Directed bench: a table of header/payload/trailer sessions with their
//   hand-computed byte streams, plus hand-written abort and start/abort cases.
//   A small FIFO model feeds the DUT and flushes when fill falls.
// -----------------------------------------------------------------------------
module tb_flash_stream_unpack;

`ifdef CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    int          nw;
    logic [31:0] trl;
    int          exp_n;
    logic [63:0] exp_bytes;   // byte i at [8i+7:8i]
    bit          hdr_err;
    bit          trl_bad;     // trailer sum wrong (only matters with checksum)
    bit          stall;       // toggle ready, insert FIFO gaps, raise fifo_low
  } vec_t;

  logic        clk2x = 1'b0;
  logic        resetn;
  logic        i_start;
  logic        i_abort;
  logic [23:0] o_len;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_starved;

  flash_stream_unpack_if bus ();

  flash_stream_unpack dut (
    .clk2x     (clk2x),
    .resetn    (resetn),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .io_strm   (bus),
    .o_len     (o_len),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_starved (o_starved)
  );

  always #5 clk2x = ~clk2x;

  // FIFO model
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_gap = 1'b0;
  logic        fifo_low_drv = 1'b0;
  logic        fill_q = 1'b0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr) || fifo_gap;
  assign bus.fifo_dout  = mem[rd_ptr[5:0]];
  assign bus.fifo_low   = fifo_low_drv;

  // Monitor counters
  int          cyc = 0;
  int          pop_cnt = 0;
  int          done_cnt = 0;
  int          starved_cnt = 0;
  int          stab_err = 0;
  int          rd_empty_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [7:0]  got_q [$];
  int          acc_q [$];

  int          n_tests = 0;
  int          n_fail = 0;
  vec_t        vecs [9];

  // FIFO pops/flush and output monitoring
  always @(posedge clk2x) begin
    cyc    <= cyc + 1;
    fill_q <= bus.fill;
    if (fill_q && !bus.fill) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd && !bus.fifo_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (bus.fifo_rd && bus.fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
    if (bus.byte_vld && bus.byte_rdy) begin
      got_q.push_back(bus.byte_data);
      acc_q.push_back(cyc);
    end
    if (prev_stall && (!bus.byte_vld || (bus.byte_data != prev_byte))) stab_err <= stab_err + 1;
    prev_stall <= bus.byte_vld && !bus.byte_rdy && !i_abort;
    prev_byte  <= bus.byte_data;
    if (o_done)    done_cnt    <= done_cnt + 1;
    if (o_starved) starved_cnt <= starved_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic vec_t mk(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                              input int nw, input logic [31:0] trl, input int n,
                              input logic [63:0] eb, input bit he, input bit tb, input bit st);
    vec_t v;
    v.hdr = hdr; v.w0 = w0; v.w1 = w1; v.nw = nw; v.trl = trl;
    v.exp_n = n; v.exp_bytes = eb; v.hdr_err = he; v.trl_bad = tb; v.stall = st;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int          b0, d0, p0, s0, sv0, re0, c, ep;
    bit          eerr;
    logic [63:0] eb;
    logic [23:0] elen;
    logic [7:0]  exp_b;
    repeat (2) @(negedge clk2x);
    b0 = got_q.size(); d0 = done_cnt; p0 = pop_cnt; s0 = stab_err;
    sv0 = starved_cnt; re0 = rd_empty_cnt;
    push(v.hdr);
    if (v.nw > 0) push(v.w0);
    if (v.nw > 1) push(v.w1);
    push(v.trl);
    fifo_low_drv = v.stall;
    i_start = 1'b1;
    @(negedge clk2x);
    i_start = 1'b0;
    check($sformatf("v%0d_fill_rise", id), bus.fill, 1'b1);
    c = 0;
    while (o_busy && (c < 300)) begin
      if (v.stall) begin
        bus.byte_rdy = c[0];
        fifo_gap     = ((c % 5) == 2);
      end
      @(negedge clk2x);
      c++;
    end
    bus.byte_rdy = 1'b1; fifo_gap = 1'b0; fifo_low_drv = 1'b0;
    check($sformatf("v%0d_terminates", id), (c < 300), 1'b1);

    eerr = v.hdr_err || ((CK == 1) && v.trl_bad);
    ep   = v.hdr_err ? 1 : (1 + v.nw + CK);
    elen = v.hdr_err ? 24'd0 : v.hdr[23:0];
    eb   = v.exp_bytes;
    check($sformatf("v%0d_nbytes", id), got_q.size() - b0, v.exp_n);
    for (int i = 0; i < v.exp_n; i++) begin
      if (b0 + i < got_q.size()) begin
        exp_b = eb[8*i +: 8];
        check($sformatf("v%0d_byte%0d", id, i), got_q[b0+i], exp_b);
      end
    end
    if (!v.stall && (v.exp_n > 0) && (got_q.size() - b0 == v.exp_n))
      check($sformatf("v%0d_back_to_back", id), acc_q[b0+v.exp_n-1] - acc_q[b0], v.exp_n - 1);
    check($sformatf("v%0d_done", id), done_cnt - d0, eerr ? 0 : 1);
    check($sformatf("v%0d_err", id), o_err, eerr);
    check($sformatf("v%0d_pops", id), pop_cnt - p0, ep);
    check($sformatf("v%0d_len", id), o_len, elen);
    check($sformatf("v%0d_fill_low", id), bus.fill, 1'b0);
    check($sformatf("v%0d_stable", id), stab_err - s0, 0);
    check($sformatf("v%0d_rd_empty", id), rd_empty_cnt - re0, 0);
    check($sformatf("v%0d_starved", id), (starved_cnt - sv0) > 0, v.stall);
  endtask

  initial begin
    int b0, d0, c;
    resetn = 1'b0; i_start = 1'b0; i_abort = 1'b0; bus.byte_rdy = 1'b1;

    //               hdr           w0            w1            nw trailer       n  expected bytes           he tb st
    vecs[0] = mk(32'hA5000006, 32'h44332211, 32'h00006655, 2, 32'h00000165, 6, 64'h0000_6655_4433_2211, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(32'h5A000004, 32'h11111111, 32'h00000000, 1, 32'h00000000, 0, 64'h0,                   1'b1, 1'b0, 1'b0);
    vecs[2] = mk(32'hA5000000, 32'h00000000, 32'h00000000, 0, 32'h00000000, 0, 64'h0,                   1'b0, 1'b0, 1'b0);
    vecs[3] = mk(32'hA5000000, 32'h00000000, 32'h00000000, 0, 32'h00000001, 0, 64'h0,                   1'b0, 1'b1, 1'b0);
    vecs[4] = mk(32'hA5000008, 32'h04030201, 32'h08070605, 2, 32'h00000024, 8, 64'h0807_0605_0403_0201, 1'b0, 1'b0, 1'b1);
    vecs[5] = mk(32'hA5100000, 32'h00000000, 32'h00000000, 0, 32'h00000000, 0, 64'h0,                   1'b1, 1'b0, 1'b0);
    vecs[6] = mk(32'hA5000005, 32'hDDCCBBAA, 32'h998877EE, 2, 32'h000003FC, 5, 64'h0000_00EE_DDCC_BBAA, 1'b0, 1'b0, 1'b0);
    vecs[7] = mk(32'hA5000004, 32'h04030201, 32'h00000000, 1, 32'h0000000A, 4, 64'h0000_0000_0403_0201, 1'b0, 1'b0, 1'b0);
    vecs[8] = mk(32'hA5000004, 32'h04030201, 32'h00000000, 1, 32'h0000000B, 4, 64'h0000_0000_0403_0201, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk2x);
    resetn = 1'b1;
    @(negedge clk2x);
    check("rst_fill",    bus.fill,      1'b0);
    check("rst_busy",    o_busy,        1'b0);
    check("rst_done",    o_done,        1'b0);
    check("rst_err",     o_err,         1'b0);
    check("rst_vld",     bus.byte_vld,  1'b0);
    check("rst_byte",    bus.byte_data, 8'h00);
    check("rst_len",     o_len,         24'd0);
    check("rst_starved", o_starved,     1'b0);
    check("rst_rd",      bus.fifo_rd,   1'b0);

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // abort mid-DATA after three accepted bytes
    repeat (2) @(negedge clk2x);
    b0 = got_q.size(); d0 = done_cnt;
    push(32'hA5000008); push(32'h04030201); push(32'h08070605); push(32'h00000024);
    i_start = 1'b1;
    @(negedge clk2x);
    i_start = 1'b0;
    c = 0;
    while (((got_q.size() - b0) < 3) && (c < 100)) begin
      @(negedge clk2x);
      c++;
    end
    check("abort_reach3", (c < 100), 1'b1);
    i_abort = 1'b1; bus.byte_rdy = 1'b0;
    @(negedge clk2x);
    i_abort = 1'b0; bus.byte_rdy = 1'b1;
    check("abort_fill", bus.fill,     1'b0);
    check("abort_vld",  bus.byte_vld, 1'b0);
    check("abort_busy", o_busy,       1'b0);
    check("abort_err",  o_err,        1'b0);
    @(negedge clk2x);
    check("abort_nbytes", got_q.size() - b0, 3);
    check("abort_done",   done_cnt - d0,     0);
    if (got_q.size() - b0 >= 3) begin
      check("abort_b0", got_q[b0],   8'h01);
      check("abort_b1", got_q[b0+1], 8'h02);
      check("abort_b2", got_q[b0+2], 8'h03);
    end
    run_vec(10, vecs[0]);

    // start and abort together in IDLE: stay idle
    @(negedge clk2x);
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk2x);
    i_start = 1'b0; i_abort = 1'b0;
    check("start_abort_busy", o_busy,   1'b0);
    check("start_abort_fill", bus.fill, 1'b0);
    @(negedge clk2x);
    check("start_abort_busy2", o_busy,  1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
